// File: rtl/bridge_pkg.sv
// Shared types for the data-side SRAM bridge: FSM state encoding and bus size codes.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_size_decode.sv
// Maps the core's byte write-enables onto bus size, low address offset and write flag.
module sram_size_decode
    import bridge_pkg::*;
(
    input  logic [3:0] i_wen,
    output logic [1:0] o_size,
    output logic [1:0] o_offset,
    output logic       o_wr
);

    always_comb begin
        o_size   = SIZE_WORD;
        o_offset = 2'b00;
        o_wr     = |i_wen;
        case (i_wen)
            4'b0011: begin o_size = SIZE_HALF; o_offset = 2'b00; end
            4'b1100: begin o_size = SIZE_HALF; o_offset = 2'b10; end
            4'b0001: begin o_size = SIZE_BYTE; o_offset = 2'b00; end
            4'b0010: begin o_size = SIZE_BYTE; o_offset = 2'b01; end
            4'b0100: begin o_size = SIZE_BYTE; o_offset = 2'b10; end
            4'b1000: begin o_size = SIZE_BYTE; o_offset = 2'b11; end
            default: begin o_size = SIZE_WORD; o_offset = 2'b00; end
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Core SRAM-style data port to split-transaction sram-like bus bridge with pipeline stall.
// Optional macro DATA_BRIDGE_BYPASS_EN forwards bus read data and drops the stall in the data_ok cycle.
module data_sram_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        longest_stall,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_done;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_wr;

    logic [1:0]  w_dec_size;
    logic [1:0]  w_dec_offset;
    logic        w_dec_wr;
    logic        w_issue;
    logic        w_complete;
    logic        w_release;
    logic        w_cur_wr;
    logic        w_addr_lo_unused;

    sram_size_decode u_size_decode (
        .i_wen    (data_sram_wen),
        .o_size   (w_dec_size),
        .o_offset (w_dec_offset),
        .o_wr     (w_dec_wr)
    );

    // Core drives word-aligned addresses; the byte offset comes from the write-enables.
    assign w_addr_lo_unused = ^data_sram_addr[1:0];

    assign w_issue  = (r_state == IDLE) & data_sram_en & ~r_done;
    assign w_cur_wr = (r_state == IDLE) ? w_dec_wr : r_wr;

    always_comb begin
        w_complete = 1'b0;
        case (r_state)
            IDLE:    w_complete = w_issue & data_addr_ok & data_data_ok;
            REQ:     w_complete = data_addr_ok & data_data_ok;
            WAIT:    w_complete = data_data_ok;
            default: w_complete = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue & ~data_addr_ok)
                    w_state_nxt = REQ;
                else if (w_issue & data_addr_ok & ~data_data_ok)
                    w_state_nxt = WAIT;
            end
            REQ: begin
                if (data_addr_ok & data_data_ok)
                    w_state_nxt = IDLE;
                else if (data_addr_ok)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                if (data_data_ok)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // In IDLE the request is presented straight from the core; afterwards from the latches.
    assign data_req   = w_issue | (r_state == REQ);
    assign data_addr  = (r_state == IDLE) ? {data_sram_addr[31:2], w_dec_offset} : r_addr;
    assign data_size  = (r_state == IDLE) ? w_dec_size : r_size;
    assign data_wr    = w_cur_wr;
    assign data_wdata = (r_state == IDLE) ? data_sram_wdata : r_wdata;

`ifdef DATA_BRIDGE_BYPASS_EN
    assign w_release       = w_complete;
    assign data_sram_rdata = (w_complete & ~w_cur_wr) ? data_rdata : r_rdata;
`else
    assign w_release       = 1'b0;
    assign data_sram_rdata = r_rdata;
`endif

    assign d_stall = data_sram_en & ~r_done & ~w_release;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_rdata <= 32'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= SIZE_BYTE;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr  <= {data_sram_addr[31:2], w_dec_offset};
                r_wdata <= data_sram_wdata;
                r_size  <= w_dec_size;
                r_wr    <= w_dec_wr;
            end
            // done blocks a duplicate issue until the whole pipeline moves on.
            if (!longest_stall)
                r_done <= 1'b0;
            else if (w_complete)
                r_done <= 1'b1;
            if (w_complete & ~w_cur_wr)
                r_rdata <= data_rdata;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed self-checking bench for data_sram_bridge (default and DATA_BRIDGE_BYPASS_EN builds).
module tb_data_sram_bridge;
    import bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        longest_stall;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    logic        ext_stall;

    int n_cmp = 0;
    int n_bad = 0;

    data_sram_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .longest_stall   (longest_stall),
        .d_stall         (d_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_rdata      (data_rdata),
        .data_data_ok    (data_data_ok)
    );

    // The pipeline stall is the OR of this bridge's stall and every other source.
    assign longest_stall = d_stall | ext_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0]  dec_wen  [5] = '{4'b0011, 4'b1100, 4'b1000, 4'b0101, 4'b0000};
    logic [31:0] dec_addr [5] = '{32'h40, 32'h40, 32'h43, 32'h47, 32'h4};
    logic [31:0] dec_exp  [5] = '{32'h40, 32'h42, 32'h43, 32'h44, 32'h4};
    logic [1:0]  dec_size [5] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2};
    logic        dec_wr   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = 4'b0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        data_addr_ok = 1'b0; data_rdata = 32'd0; data_data_ok = 1'b0; ext_stall = 1'b0;
        #1 rst = 1'b0;
        #10;
        chk("rst_req", data_req, 1'b0);
        chk("rst_stall", d_stall, 1'b0);
        chk("rst_rdata", data_sram_rdata, 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        tick();
        rst = 1'b1;

        // Size/offset decode observed in IDLE with no access pending.
        for (int i = 0; i < 5; i++) begin
            data_sram_wen = dec_wen[i]; data_sram_addr = dec_addr[i];
            #1;
            chk("dec_addr", data_addr, dec_exp[i]);
            chk("dec_size", data_size, dec_size[i]);
            chk("dec_wr", data_wr, dec_wr[i]);
            chk("dec_req", data_req, 1'b0);
        end

        // Read with addr_ok in cycle 0 and data_ok in cycle 2.
        tick();
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h1000; data_addr_ok = 1'b1;
        #1;
        chk("rd_req", data_req, 1'b1);
        chk("rd_size", data_size, 2'd2);
        chk("rd_addr", data_addr, 32'h1000);
        chk("rd_wr", data_wr, 1'b0);
        chk("rd_stall0", d_stall, 1'b1);
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("rd_req1", data_req, 1'b0);
        chk("rd_stall1", d_stall, 1'b1);
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        #1;
`ifdef DATA_BRIDGE_BYPASS_EN
        chk("rd_stall2", d_stall, 1'b0);
        chk("rd_byp", data_sram_rdata, 32'hDEADBEEF);
`else
        chk("rd_stall2", d_stall, 1'b1);
`endif
        tick();
        data_data_ok = 1'b0; data_rdata = 32'd0;
`ifdef DATA_BRIDGE_BYPASS_EN
        data_sram_en = 1'b0;
`endif
        #1;
        chk("rd_stall3", d_stall, 1'b0);
        chk("rd_rdata", data_sram_rdata, 32'hDEADBEEF);
        chk("rd_noreq", data_req, 1'b0);
        tick();
        data_sram_en = 1'b0;

        // Byte store held in REQ for three cycles; en drops after the issue cycle.
        tick();
        data_sram_en = 1'b1; data_sram_wen = 4'b0100; data_sram_addr = 32'h2004; data_sram_wdata = 32'h00AB0000;
        #1;
        chk("st_req0", data_req, 1'b1);
        chk("st_wr0", data_wr, 1'b1);
        chk("st_size0", data_size, 2'd0);
        chk("st_addr0", data_addr, 32'h2006);
        tick();
        data_sram_en = 1'b0; data_sram_wen = 4'b0000; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        #1;
        chk("st_req1", data_req, 1'b1);
        chk("st_addr1", data_addr, 32'h2006);
        chk("st_size1", data_size, 2'd0);
        chk("st_wr1", data_wr, 1'b1);
        chk("st_wdata1", data_wdata, 32'h00AB0000);
        tick();
        #1;
        chk("st_req2", data_req, 1'b1);
        chk("st_addr2", data_addr, 32'h2006);
        tick();
        data_addr_ok = 1'b1;
        #1;
        chk("st_req3", data_req, 1'b1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        #1;
        chk("st_state_wait", 32'(dut.r_state), 32'(WAIT));
        chk("st_req4", data_req, 1'b0);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("st_state_idle", 32'(dut.r_state), 32'(IDLE));
        chk("st_rdata_kept", data_sram_rdata, 32'hDEADBEEF);

        // done hold-off: the rest of the pipeline stays stalled for 4 cycles after completion.
        tick();
        data_sram_en = 1'b1; data_sram_addr = 32'h1010; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D; ext_stall = 1'b1;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_req", data_req, 1'b0);
            chk("hold_stall", d_stall, 1'b0);
            chk("hold_rdata", data_sram_rdata, 32'hCAFEF00D);
            tick();
        end
        ext_stall = 1'b0;
        #1;
        chk("hold_last_req", data_req, 1'b0);
        tick();
        // Reissue with addr_ok and data_ok together in the issue cycle.
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
        #1;
        chk("same_req", data_req, 1'b1);
`ifdef DATA_BRIDGE_BYPASS_EN
        chk("same_stall", d_stall, 1'b0);
        chk("same_byp", data_sram_rdata, 32'h0BADF00D);
`else
        chk("same_stall", d_stall, 1'b1);
`endif
        tick();
        data_sram_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk("same_req1", data_req, 1'b0);
        chk("same_stall1", d_stall, 1'b0);
        chk("same_rdata", data_sram_rdata, 32'h0BADF00D);
        chk("same_state", 32'(dut.r_state), 32'(IDLE));

        // Reset asserted while waiting for data_ok.
        tick();
        data_sram_en = 1'b1; data_sram_addr = 32'h5000; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #1;
        chk("mid_wait", 32'(dut.r_state), 32'(WAIT));
        data_sram_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_req", data_req, 1'b0);
        chk("mid_stall", d_stall, 1'b0);
        chk("mid_rdata", data_sram_rdata, 32'd0);
        chk("mid_state", 32'(dut.r_state), 32'(IDLE));
        tick();
        rst = 1'b1;
        data_sram_en = 1'b1; data_sram_addr = 32'h6000;
        #1;
        chk("post_req", data_req, 1'b1);
        chk("post_addr", data_addr, 32'h6000);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11223344;
        tick();
        data_sram_en = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk("post_rdata", data_sram_rdata, 32'h11223344);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Downstream neighbour of the five-stage MIPS core on the data side. Converts the core's single-cycle SRAM-style memory-stage port (enable, byte write-enables, word-aligned address) into a split-transaction sram-like bus (req/addr_ok/data_ok). Raises a stall to the hazard unit while a transaction is outstanding. Holds read data until the whole pipeline releases its stall, so an access is never issued twice.

## Interface
- No parameters; widths are fixed at 32-bit address and data.
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- data_sram_en  in  1  memory-stage access valid (load or store)
- data_sram_wen  in  4  byte write-enables; 0000 means read
- data_sram_addr  in  32  word-aligned address; bits [1:0] are ignored
- data_sram_wdata  in  32  store data, already lane-shifted
- data_sram_rdata  out  32  word read data returned to the load unit
- longest_stall  in  1  OR of all pipeline stall sources, this bridge's own stall included
- d_stall  out  1  this bridge requests a pipeline stall
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = halfword, 2 = word
- data_addr  out  32  byte address
- data_wdata  out  32  write data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  bus read data
- data_data_ok  in  1  response valid

## Operation
- FSM states: IDLE, REQ (waiting for addr_ok), WAIT (waiting for data_ok).
- **Transitions:**
  - IDLE to REQ on en & ~done & ~addr_ok.
  - IDLE to WAIT on en & ~done & addr_ok & ~data_ok.
  - REQ to WAIT on addr_ok & ~data_ok.
  - Any state to IDLE on completion, where completion = data_ok in WAIT, or addr_ok & data_ok together in IDLE/REQ.
- **Request signals:**
  - In IDLE, data_req = en & ~done, and addr/size/wr/wdata are driven combinationally from core inputs.
  - The issue cycle latches those values. From then on, REQ and WAIT drive the latched values.
  - data_req stays 1 and stable throughout REQ, even if en drops.
- **Size and address decode:**
  - wen 0000: size 2, offset 00, wr = 0.
  - wen 1111: size 2, offset 00.
  - wen 0011: size 1, offset 00.
  - wen 1100: size 1, offset 10.
  - wen 0001, 0010, 0100 and 1000: size 0, with offset 00, 01, 10 and 11 respectively.
  - Any other wen pattern decodes as size 2, offset 00.
  - data_addr = {addr[31:2], offset}.
- **done flag:**
  - Set on completion while longest_stall is still 1.
  - Cleared on any cycle with longest_stall = 0.
  - While done is 1, no new request is issued and d_stall is 0.
- d_stall = en & ~done & ~release. In the default build, release = 0; see Configuration for the bypass build.
- **Read data register (rdata_r):**
  - Loaded with data_rdata on completion of a read.
  - Held otherwise; stores leave it unchanged.
  - data_sram_rdata = rdata_r, except in the bypass build (see Configuration).
- Once issued, a transaction always completes. Dropping en does not cancel it; the bridge returns to IDLE.

## Timing
- **Reset values:** state IDLE, done 0, rdata_r 0, data_req 0, d_stall 0, latched address/size/wdata/wr all 0.
- **Best-case latency, default build:**
  - Cycle 0: addr_ok.
  - Cycle 1: data_ok. rdata_r is loaded at this edge.
  - Cycle 2: d_stall falls.
- A read's result is valid on data_sram_rdata from the cycle d_stall falls until the next issue.
- Simultaneous addr_ok and data_ok in the issue cycle counts as a one-cycle completion.
- data_ok never precedes addr_ok; the bridge ignores data_ok when no transaction is outstanding.
- If reset is asserted mid-transaction, the bridge returns to IDLE immediately. The bus slave shares rst, so no response is awaited afterwards.

## Configuration
- DATA_BRIDGE_BYPASS_EN
- **Defined:** release = completion this cycle. In the completion cycle, data_sram_rdata = data_rdata and d_stall falls in the same cycle as data_ok. Best-case latency is one cycle shorter.
- **Undefined:** release = 0 and data_sram_rdata always equals rdata_r.
- Bus-side behaviour is identical in both builds.

## Structure
- Package bridge_pkg holds:
  - the FSM state enum (IDLE, REQ, WAIT);
  - size constants SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2.
- One sub-module, sram_size_decode: combinational, takes wen and produces size, offset and wr.
- The FSM, latches and done logic live in the top module.

## Test plan
- **Read, addr_ok and data_ok in separate cycles:** read addr 0x1000 with addr_ok in cycle 0 and data_rdata 0xDEADBEEF with data_ok in cycle 2. Expect size = 2, data_addr = 0x1000, d_stall high for cycles 0–2, then rdata = 0xDEADBEEF with d_stall low in cycle 3.
- **Byte store:** wen 0100, addr 0x2004. Expect data_wr = 1, size = 0, data_addr = 0x2006. Hold addr_ok low for 3 cycles: data_req and data_addr stay stable throughout, and en dropping at cycle 1 does not withdraw req.
- **done hold-off:** keep longest_stall = 1 for 4 cycles after completion. Expect no second data_req; d_stall = 0 and rdata held. longest_stall = 0 clears done, and the next en reissues.
- **Same-cycle handshake:** addr_ok and data_ok together in the issue cycle. Expect a single transaction, return to IDLE, and rdata captured.
- **Bypass build:** with DATA_BRIDGE_BYPASS_EN defined, d_stall falls in the data_ok cycle and data_sram_rdata equals data_rdata in that cycle.
- **Reset mid-transaction:** assert rst low while in WAIT. Expect data_req = 0, d_stall = 0, rdata = 0, state IDLE, and a fresh request after rst is released.
